// File: rtl/gcd_input_loader.sv
// Operand loader for the GCD core: synchronises and debounces one push-button,
// latches X then Y from a shared switch bus, then strobes okey_o for one cycle.
// Optional GCD_LOADER_ZERO_REJECT_EN: presses while data_i==0 are ignored.
module gcd_input_loader #(
  parameter int DATA_BITS = 4,
  parameter int DB_CYCLES = 8,
  parameter int DB_BITS   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 btn_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic [DATA_BITS-1:0] x_o,
  output logic [DATA_BITS-1:0] y_o,
  output logic                 okey_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    LOAD_X = 2'b00,
    LOAD_Y = 2'b01,
    FIRE   = 2'b10,
    HOLD   = 2'b11
  } state_t;

  localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'(DB_CYCLES - 1);

  logic               btn_sync_p0;
  logic               btn_s;
  logic               btn_db;
  logic               btn_db_q;
  logic [DB_BITS-1:0] db_cnt;
  logic               press;
  logic               accept;

  state_t                 state, state_nxt;
  logic [DATA_BITS-1:0]   x_nxt, y_nxt;

  // Stage 0/1: two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_sync_p0 <= 1'b0;
      btn_s       <= 1'b0;
    end else begin
      btn_sync_p0 <= btn_i;
      btn_s       <= btn_sync_p0;
    end
  end

  // Debounce: a level change is accepted only after DB_CYCLES stable samples
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = btn_db & ~btn_db_q;

`ifdef GCD_LOADER_ZERO_REJECT_EN
  assign accept = press & (|data_i);
`else
  assign accept = press;
`endif

  always_comb begin
    state_nxt = state;
    x_nxt     = x_o;
    y_nxt     = y_o;
    unique case (state)
      LOAD_X: if (accept) begin
        x_nxt     = data_i;
        state_nxt = LOAD_Y;
      end
      LOAD_Y: if (accept) begin
        y_nxt     = data_i;
        state_nxt = FIRE;
      end
      FIRE:   state_nxt = HOLD;
      HOLD: if (accept) begin
        x_nxt     = data_i;
        state_nxt = LOAD_Y;
      end
    endcase
  end

  // Stage 2: FSM state and operand registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= LOAD_X;
      x_o   <= '0;
      y_o   <= '0;
    end else begin
      state <= state_nxt;
      x_o   <= x_nxt;
      y_o   <= y_nxt;
    end
  end

  assign okey_o  = (state == FIRE);
  assign state_o = state;

endmodule

// File: tb/tb_gcd_input_loader.sv
// Self-checking bench for gcd_input_loader: latency, table-driven press sequence,
// glitch rejection, async reset mid-load, zero operand and randomized presses.
module tb_gcd_input_loader;

  localparam int DW = 4;
  localparam int DB = 8;
`ifdef GCD_LOADER_ZERO_REJECT_EN
  localparam bit ZREJ = 1'b1;
`else
  localparam bit ZREJ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn = 1'b0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] x_o, y_o;
  logic          okey_o;
  logic [1:0]    state_o;

  int checks = 0;
  int errors = 0;
  int okey_seen = 0;
  logic okey_prev = 1'b0;

  gcd_input_loader #(.DATA_BITS(DW), .DB_CYCLES(DB), .DB_BITS(4)) dut (
    .clk_i(clk), .rst_i(rst), .btn_i(btn), .data_i(data),
    .x_o(x_o), .y_o(y_o), .okey_o(okey_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // okey_o must be a single-cycle strobe and only appear in the FIRE encoding
  always @(negedge clk) begin
    if (okey_o) begin
      okey_seen++;
      check("okey_single_cycle", okey_prev, 0);
      check("okey_state_fire", state_o, 2);
    end
    okey_prev = okey_o;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(3);
  endtask

  // Short high bounces (< DB cycles) precede a clean 20-cycle press and release
  task automatic press_btn(input logic [DW-1:0] d, input int nbounce);
    data = d;
    okey_seen = 0;
    for (int b = 0; b < nbounce; b++) begin
      btn = 1'b1;
      cycles($urandom_range(1, DB - 1));
      btn = 1'b0;
      cycles($urandom_range(1, 3));
    end
    btn = 1'b1;
    cycles(20);
    btn = 1'b0;
    cycles(20);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int exp_x;
    int exp_y;
    int exp_state;
    int exp_okey;
  } vec_t;

  vec_t vecs[5];

  // Reference model: operands and whether the next press is a Y press
  int  m_x, m_y, m_exp_okey;
  bit  m_wait_y, m_loaded;

  function automatic int model_state();
    if (m_wait_y) return 1;
    return m_loaded ? 3 : 0;
  endfunction

  task automatic model_press(input int d);
    m_exp_okey = 0;
    if (ZREJ && d == 0) return;
    if (!m_wait_y) begin
      m_x = d;
      m_wait_y = 1'b1;
    end else begin
      m_y = d;
      m_wait_y = 1'b0;
      m_loaded = 1'b1;
      m_exp_okey = 1;
    end
  endtask

  initial begin
    vecs[0] = '{data: 4'd12, exp_x: 12, exp_y: 0, exp_state: 1, exp_okey: 0};
    vecs[1] = '{data: 4'd8,  exp_x: 12, exp_y: 8, exp_state: 3, exp_okey: 1};
    vecs[2] = '{data: 4'd9,  exp_x: 9,  exp_y: 8, exp_state: 1, exp_okey: 0};
    vecs[3] = '{data: 4'd3,  exp_x: 9,  exp_y: 3, exp_state: 3, exp_okey: 1};
    vecs[4] = '{data: 4'd15, exp_x: 15, exp_y: 3, exp_state: 1, exp_okey: 0};

    // Reset values, asserted asynchronously before any clock edge
    rst = 1'b1;
    #1;
    check("rst_x", x_o, 0);
    check("rst_y", y_o, 0);
    check("rst_okey", okey_o, 0);
    check("rst_state", state_o, 0);
    cycles(3);
    rst = 1'b0;
    cycles(3);

    // Latency: next edge samples btn=1 (edge 0); FSM acts at edge DB+2
    data = 4'd12;
    btn = 1'b1;
    cycles(DB + 2);
    check("lat_before_state", state_o, 0);
    check("lat_before_x", x_o, 0);
    cycles(1);
    check("lat_at_state", state_o, 1);
    check("lat_at_x", x_o, 12);
    cycles(9);
    btn = 1'b0;
    cycles(20);
    check("lat_y_untouched", y_o, 0);

    // Table-driven press sequence from a fresh reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press_btn(vecs[i].data, 0);
      check($sformatf("vec%0d_x", i), x_o, vecs[i].exp_x);
      check($sformatf("vec%0d_y", i), y_o, vecs[i].exp_y);
      check($sformatf("vec%0d_state", i), state_o, vecs[i].exp_state);
      check($sformatf("vec%0d_okey", i), okey_seen, vecs[i].exp_okey);
    end

    // Glitch rejection in LOAD_X: high 5, low 5, high 5 never reaches DB cycles
    do_reset();
    data = 4'd6;
    btn = 1'b1; cycles(5);
    btn = 1'b0; cycles(5);
    btn = 1'b1; cycles(5);
    btn = 1'b0; cycles(20);
    check("glitch_state", state_o, 0);
    check("glitch_x", x_o, 0);

    // Async reset mid-load, between clock edges
    do_reset();
    press_btn(4'd12, 0);
    check("midload_pre_state", state_o, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midload_rst_x", x_o, 0);
    check("midload_rst_state", state_o, 0);
    check("midload_rst_y", y_o, 0);
    @(negedge clk);
    rst = 1'b0;
    cycles(2);
    press_btn(4'd5, 0);
    check("midload_after_x", x_o, 5);
    check("midload_after_y", y_o, 0);
    check("midload_after_state", state_o, 1);

    // Zero operand pressed in LOAD_X
    do_reset();
    press_btn(4'd0, 0);
    check("zero_x", x_o, 0);
    check("zero_state", state_o, ZREJ ? 0 : 1);

    // Randomized presses with bounce, against the reference model
    do_reset();
    m_x = 0; m_y = 0; m_wait_y = 1'b0; m_loaded = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int d;
      d = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 15);
      press_btn(DW'(d), $urandom_range(0, 3));
      model_press(d);
      check($sformatf("rnd%0d_x", i), x_o, m_x);
      check($sformatf("rnd%0d_y", i), y_o, m_y);
      check($sformatf("rnd%0d_state", i), state_o, model_state());
      check($sformatf("rnd%0d_okey", i), okey_seen, m_exp_okey);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
